// File: rtl/fetch_stage_pkg.sv
// Shared encodings for the IF stage: PC-source select, bubble instruction,
// fetch FSM state codes and the IF/ID register payload.
package fetch_stage_pkg;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b10;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  // 32-bit modulo increment; 0xFFFF_FFFC wraps to 0
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response handshake between fetch and imem.
interface fetch_stage_if;
  logic        Fo_imemReq;
  logic [31:0] Fo_imemAddr;
  logic        Fi_imemReady;
  logic [31:0] Fi_imemRdata;

  modport master (output Fo_imemReq, Fo_imemAddr, input Fi_imemReady, Fi_imemRdata);
  modport slave  (input Fo_imemReq, Fo_imemAddr, output Fi_imemReady, Fi_imemRdata);
endinterface

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: reset > clear (bubble) > hold when disabled >
// load > bubble when nothing was delivered.
module fetch_ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  logic  clear,
  input  logic  load,
  input  ifid_t load_val,
  output ifid_t ifid
);

  ifid_t ifid_d, ifid_q;
  ifid_t bubble;

  always_comb begin
    bubble          = '0;
    bubble.inst     = NOP_INST;
  end

  // next IF/ID contents by priority
  always_comb begin
    ifid_d = ifid_q;
    if (clear) begin
      ifid_d = bubble;
    end else if (en) begin
      ifid_d = load ? load_val : bubble;
    end
  end

  // register with synchronous reset to bubble
  always_ff @(posedge clk) begin
    if (reset) ifid_q <= bubble;
    else       ifid_q <= ifid_d;
  end

  assign ifid = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues imem requests and feeds the IF/ID register.
//
//  state   | meaning
//  FETCH   | request outstanding at pc_q; deliver or redirect on ready
//  HOLD    | data captured in buf_q while stalled; no request
//  DISCARD | redirected while request pending; wait for ready, then drop data
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Ei_PCSrc,
  input  logic [31:0]          Ei_PCPlusImm,
  input  logic [31:0]          Ei_ALUResult,
  input  logic                 Fi_stall,
  input  logic                 Di_flush,
  fetch_stage_if.master        imem,
  output logic [31:0]          Do_inst,
  output logic [31:0]          Do_PC,
  output logic [31:0]          Do_PCPlus4,
  output logic                 Do_valid
);

  logic [1:0]  state_d, state_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] redir_pc_d, redir_pc_q;
  logic [31:0] buf_d, buf_q;

  logic        redirect;
  logic [31:0] target;
  logic        load;
  logic [31:0] load_inst;
  ifid_t       load_val;
  ifid_t       ifid;

  // PCSrc 11 falls through as sequential
  always_comb begin
    redirect = (Ei_PCSrc == PCSRC_BR) || (Ei_PCSrc == PCSRC_JALR);
    target   = (Ei_PCSrc == PCSRC_BR) ? Ei_PCPlusImm : (Ei_ALUResult & ~32'h1);
  end

  assign imem.Fo_imemReq  = !reset && (state_q != ST_HOLD);
  assign imem.Fo_imemAddr = pc_q;

  // fetch FSM and next-PC selection; redirect outranks stall
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_pc_d = redir_pc_q;
    buf_d      = buf_q;
    load       = 1'b0;
    load_inst  = buf_q;
    case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          if (imem.Fi_imemReady) begin
            pc_d = target;
          end else begin
            redir_pc_d = target;
            state_d    = ST_DISCARD;
          end
        end else if (imem.Fi_imemReady) begin
          if (!Fi_stall) begin
            load      = 1'b1;
            load_inst = imem.Fi_imemRdata;
            pc_d      = next_seq_pc(pc_q);
          end else begin
            buf_d   = imem.Fi_imemRdata;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = ST_FETCH;
        end else if (!Fi_stall) begin
          load    = 1'b1;
          pc_d    = next_seq_pc(pc_q);
          state_d = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (imem.Fi_imemReady) begin
          pc_d    = redirect ? target : redir_pc_q;
          state_d = ST_FETCH;
        end else if (redirect) begin
          redir_pc_d = target;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // state registers; imem shares this reset so in-flight data is simply lost
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      redir_pc_q <= RESET_PC;
      buf_q      <= NOP_INST;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
      buf_q      <= buf_d;
    end
  end

  // IF/ID load payload always carries the current PC
  always_comb begin
    load_val          = '0;
    load_val.inst     = load_inst;
    load_val.pc       = pc_q;
    load_val.pc_plus4 = next_seq_pc(pc_q);
    load_val.valid    = 1'b1;
  end

  fetch_ifid_reg #(.NOP_INST(NOP_INST)) u_ifid (
    .clk      (clk),
    .reset    (reset),
    .en       (!Fi_stall),
    .clear    (Di_flush),
    .load     (load),
    .load_val (load_val),
    .ifid     (ifid)
  );

  assign Do_inst    = ifid.inst;
  assign Do_PC      = ifid.pc;
  assign Do_PCPlus4 = ifid.pc_plus4;
  assign Do_valid   = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected request and
// IF/ID values per cycle; a negedge monitor pops and compares them.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Ei_PCSrc;
  logic [31:0] Ei_PCPlusImm;
  logic [31:0] Ei_ALUResult;
  logic        Fi_stall;
  logic        Di_flush;
  logic [31:0] Do_inst;
  logic [31:0] Do_PC;
  logic [31:0] Do_PCPlus4;
  logic        Do_valid;

  always #5 clk = ~clk;

  fetch_stage_if imem ();

  // imem model: returns a tag derived from the address whenever ready
  assign imem.Fi_imemRdata = imem.Fi_imemReady ? (32'h1000_0000 | imem.Fo_imemAddr) : 32'hDEAD_BEEF;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .Ei_PCSrc     (Ei_PCSrc),
    .Ei_PCPlusImm (Ei_PCPlusImm),
    .Ei_ALUResult (Ei_ALUResult),
    .Fi_stall     (Fi_stall),
    .Di_flush     (Di_flush),
    .imem         (imem),
    .Do_inst      (Do_inst),
    .Do_PC        (Do_PC),
    .Do_PCPlus4   (Do_PCPlus4),
    .Do_valid     (Do_valid)
  );

  typedef struct {
    logic        rst, rdy, stl, fl;
    logic [1:0]  src;
    logic [31:0] imm, alu;
    logic        req;
    logic [31:0] addr;
    logic        ld;
    logic [31:0] inst, pc, pc4;
  } vec_t;

  typedef struct {
    logic        req;
    logic [31:0] addr;
  } req_exp_t;

  typedef struct {
    logic        valid;
    logic [31:0] inst, pc, pc4;
    logic        chk_pc;
  } ifid_exp_t;

  vec_t      vecs[$];
  req_exp_t  req_q[$];
  ifid_exp_t ifid_q[$];
  ifid_exp_t last_ifid;

  int   checks = 0;
  int   errors = 0;
  logic upd = 1'b0;
  logic stim_done = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic rdy, input logic stl, input logic fl,
                     input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu,
                     input logic req, input logic [31:0] addr,
                     input logic ld, input logic [31:0] inst, input logic [31:0] pc,
                     input logic [31:0] pc4);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.stl = stl; v.fl = fl; v.src = src;
    v.imm = imm; v.alu = alu; v.req = req; v.addr = addr;
    v.ld = ld; v.inst = inst; v.pc = pc; v.pc4 = pc4;
    vecs.push_back(v);
  endtask

  // an IF/ID update happens at an edge unless a plain stall holds it
  always @(posedge clk) upd <= reset | Di_flush | !Fi_stall;

  initial begin
    forever begin
      @(negedge clk);
      if (upd) begin
        if (ifid_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ifid_queue: got empty expected entry at %0t", $time);
        end else begin
          ifid_exp_t e;
          e = ifid_q.pop_front();
          last_ifid = e;
          check32("Do_valid", {31'd0, Do_valid}, {31'd0, e.valid});
          check32("Do_inst", Do_inst, e.inst);
          if (e.valid || e.chk_pc) begin
            check32("Do_PC", Do_PC, e.pc);
            check32("Do_PCPlus4", Do_PCPlus4, e.pc4);
          end
        end
      end else begin
        check32("hold_valid", {31'd0, Do_valid}, {31'd0, last_ifid.valid});
        check32("hold_inst", Do_inst, last_ifid.inst);
        if (last_ifid.valid) begin
          check32("hold_PC", Do_PC, last_ifid.pc);
          check32("hold_PCPlus4", Do_PCPlus4, last_ifid.pc4);
        end
      end
      if (!stim_done) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_queue: got empty expected entry at %0t", $time);
        end else begin
          req_exp_t r;
          r = req_q.pop_front();
          check32("Fo_imemReq", {31'd0, imem.Fo_imemReq}, {31'd0, r.req});
          if (r.req) check32("Fo_imemAddr", imem.Fo_imemAddr, r.addr);
        end
        checks++;
        if (imem.Fi_imemReady && !imem.Fo_imemReq) begin
          errors++;
          $display("FAIL ready_without_req: got ready=1 req=0 at %0t", $time);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; Fi_stall = 1'b0; Di_flush = 1'b0; Ei_PCSrc = 2'b00;
    Ei_PCPlusImm = '0; Ei_ALUResult = '0; imem.Fi_imemReady = 1'b0;

    //  rst rdy stl fl src    imm            alu           req addr          ld inst           pc            pc4
    add(1, 0, 0, 0, 2'b00, 32'h0,          32'h0,        0, 32'h0,         0, 32'h0,         32'h0,        32'h0);
    add(0, 1, 0, 0, 2'b00, 32'h0,          32'h0,        1, 32'h0,         1, 32'h1000_0000, 32'h0,        32'h4);
    add(0, 1, 0, 0, 2'b00, 32'h0,          32'h0,        1, 32'h4,         1, 32'h1000_0004, 32'h4,        32'h8);
    add(0, 0, 0, 0, 2'b00, 32'h0,          32'h0,        1, 32'h8,         0, 32'h0,         32'h0,        32'h0);
    add(0, 0, 0, 0, 2'b00, 32'h0,          32'h0,        1, 32'h8,         0, 32'h0,         32'h0,        32'h0);
    add(0, 1, 0, 0, 2'b00, 32'h0,          32'h0,        1, 32'h8,         1, 32'h1000_0008, 32'h8,        32'hC);
    add(0, 1, 1, 0, 2'b00, 32'h0,          32'h0,        1, 32'hC,         0, 32'h0,         32'h0,        32'h0);
    add(0, 0, 1, 0, 2'b00, 32'h0,          32'h0,        0, 32'h0,         0, 32'h0,         32'h0,        32'h0);
    add(0, 0, 0, 0, 2'b00, 32'h0,          32'h0,        0, 32'h0,         1, 32'h1000_000C, 32'hC,        32'h10);
    add(0, 1, 0, 1, 2'b01, 32'h100,        32'h0,        1, 32'h10,        0, 32'h0,         32'h0,        32'h0);
    add(0, 1, 0, 0, 2'b00, 32'h0,          32'h0,        1, 32'h100,       1, 32'h1000_0100, 32'h100,      32'h104);
    add(0, 0, 0, 1, 2'b10, 32'h0,          32'h203,      1, 32'h104,       0, 32'h0,         32'h0,        32'h0);
    add(0, 0, 0, 0, 2'b00, 32'h0,          32'h0,        1, 32'h104,       0, 32'h0,         32'h0,        32'h0);
    add(0, 1, 0, 0, 2'b00, 32'h0,          32'h0,        1, 32'h104,       0, 32'h0,         32'h0,        32'h0);
    add(0, 1, 0, 0, 2'b00, 32'h0,          32'h0,        1, 32'h202,       1, 32'h1000_0202, 32'h202,      32'h206);
    add(0, 0, 0, 1, 2'b01, 32'h300,        32'h0,        1, 32'h206,       0, 32'h0,         32'h0,        32'h0);
    add(1, 0, 0, 0, 2'b00, 32'h0,          32'h0,        0, 32'h0,         0, 32'h0,         32'h0,        32'h0);
    add(0, 1, 0, 0, 2'b00, 32'h0,          32'h0,        1, 32'h0,         1, 32'h1000_0000, 32'h0,        32'h4);
    add(0, 1, 0, 1, 2'b01, 32'hFFFF_FFFC,  32'h0,        1, 32'h4,         0, 32'h0,         32'h0,        32'h0);
    add(0, 1, 0, 0, 2'b00, 32'h0,          32'h0,        1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0);
    add(0, 1, 0, 0, 2'b11, 32'h700,        32'h701,      1, 32'h0,         1, 32'h1000_0000, 32'h0,        32'h4);
    add(0, 0, 0, 1, 2'b01, 32'h400,        32'h0,        1, 32'h4,         0, 32'h0,         32'h0,        32'h0);
    add(0, 0, 0, 1, 2'b10, 32'h0,          32'h501,      1, 32'h4,         0, 32'h0,         32'h0,        32'h0);
    add(0, 1, 0, 0, 2'b00, 32'h0,          32'h0,        1, 32'h4,         0, 32'h0,         32'h0,        32'h0);
    add(0, 1, 1, 0, 2'b00, 32'h0,          32'h0,        1, 32'h500,       0, 32'h0,         32'h0,        32'h0);
    add(0, 0, 1, 1, 2'b01, 32'h600,        32'h0,        0, 32'h0,         0, 32'h0,         32'h0,        32'h0);
    add(0, 1, 0, 0, 2'b00, 32'h0,          32'h0,        1, 32'h600,       1, 32'h1000_0600, 32'h600,      32'h604);
    add(0, 0, 0, 0, 2'b00, 32'h0,          32'h0,        1, 32'h604,       0, 32'h0,         32'h0,        32'h0);

    // initial reset edge presents a bubble with zeroed PCs
    begin
      ifid_exp_t e0;
      e0.valid = 1'b0; e0.inst = NOP; e0.pc = 32'h0; e0.pc4 = 32'h0; e0.chk_pc = 1'b1;
      ifid_q.push_back(e0);
    end

    foreach (vecs[i]) begin
      req_exp_t  r;
      ifid_exp_t e;
      @(posedge clk);
      #1;
      reset             = vecs[i].rst;
      imem.Fi_imemReady = vecs[i].rdy;
      Fi_stall          = vecs[i].stl;
      Di_flush          = vecs[i].fl;
      Ei_PCSrc          = vecs[i].src;
      Ei_PCPlusImm      = vecs[i].imm;
      Ei_ALUResult      = vecs[i].alu;
      r.req  = vecs[i].req;
      r.addr = vecs[i].addr;
      req_q.push_back(r);
      if (vecs[i].rst || vecs[i].fl || !vecs[i].stl) begin
        e.valid  = vecs[i].ld;
        e.inst   = vecs[i].ld ? vecs[i].inst : NOP;
        e.pc     = vecs[i].pc;
        e.pc4    = vecs[i].pc4;
        e.chk_pc = vecs[i].rst;
        ifid_q.push_back(e);
      end
    end

    @(posedge clk);
    stim_done = 1'b1;
    @(negedge clk);
    #1;
    check32("req_queue_drained", req_q.size(), 32'd0);
    check32("ifid_queue_drained", ifid_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
